hdmi_tx_config_sequencer: RTL and testbench
===========================================

# hdmi_tx_config_sequencer

Sequences the HDMI transmitter's power-up register programming over the I2C_controller. After reset it waits a power-up delay, then walks a fixed table of {register, value} pairs. Each pair is issued as one three-byte I2C write: slave address, register, data. Every transfer is checked for NACK and retried. Sits between the top level and I2C_controller, sharing its clock_100khz domain.

## Interface
- `SLAVE_ADDR`, default 8'h72: 8-bit write address of the transmitter.
- `NUM_REGS`, default 10: number of table entries (1–255).
- `POWERUP_DELAY`, default 20000: cycles to wait after reset before the first transfer (200 ms at 100 kHz).
- `GAP_CYCLES`, default 4: idle cycles between transfers.
- `MAX_RETRY`, default 3: retries per entry before error.
- `TIMEOUT`, default 64: maximum cycles in WAIT before the transfer counts as failed.

Ports:
- `clock` in 1: sequencer clock, the same clock_100khz that drives I2C_controller.
- `MR_n` in 1: asynchronous, active-low reset.
- `reconfigure` in 1: level, sampled in DONE/ERROR; restarts the table from index 0, skipping the power-up delay.
- `xfer_stop` in 1: I2C_controller `stop`; a low for one cycle marks transfer end.
- `xfer_nack` in 1: I2C_controller `ack`; high means SDA was high in an ACK slot (NACK).
- `start` out 1: one-cycle transfer request to I2C_controller.
- `slave_address` out 8: constant SLAVE_ADDR.
- `register_data` out 16: {reg, value} of the current entry.
- `busy` out 1: high from leaving IDLE until DONE/ERROR.
- `config_done` out 1: level; all entries written.
- `config_error` out 1: level; an entry exhausted its retries.
- `entry_index` out 8: current table index.

## Operation
- States: PWRUP, LOAD, START, WAIT, CHECK, GAP, DONE, ERROR.
- PWRUP: a down-counter runs from POWERUP_DELAY−1. At 0 → LOAD with index=0, retry=0.
- LOAD: `register_data` ← table[index]. → START.
- START: `start`=1 for exactly this cycle; clear the NACK latch and the timeout counter. → WAIT.
- WAIT: the NACK latch sets on any cycle with `xfer_nack`=1. This latch is sticky because the controller clears `ack` before `stop` falls.
  - `xfer_stop`=0 → CHECK.
  - Timeout counter reaches TIMEOUT−1 → set the NACK latch and go to CHECK.
- CHECK, NACK latched:
  - retry<MAX_RETRY: retry+1 → GAP, same index.
  - Otherwise → ERROR.
- CHECK, no NACK:
  - retry←0. index==NUM_REGS−1 → DONE.
  - Otherwise index+1 → GAP.
- GAP: GAP_CYCLES idle cycles, then → LOAD.
- DONE/ERROR: hold their flag. `reconfigure`=1 → clear both flags, index=0, retry=0 → LOAD.
- Table: fixed case ROM indexed by `entry_index`; entries past NUM_REGS return 16'h0000. Entries 0–9: 4110, 9803, 9AE0, 9C30, 9D61, A2A4, A3A4, E0D0, F900, 1630.
- `register_data` is stable from LOAD through CHECK; the controller latches bytes mid-transfer.

## Timing
- Reset values:
  - `start`=0, `register_data`=0, `busy`=0, `config_done`=0, `config_error`=0, `entry_index`=0.
  - `slave_address`=SLAVE_ADDR.
  - State=PWRUP with the counter loaded.
- All outputs are registered.
- `start` is high exactly 1 cycle per attempt and never while `xfer_stop`=0.
- START→WAIT→…: the first WAIT cycle follows `start` by 1 cycle. The controller stops asserting `stop`=1 after about 2+9·3·3 cycles.
- Per-entry overhead, excluding the controller: LOAD 1 + START 1 + CHECK 1 + GAP GAP_CYCLES.
- Simultaneous `xfer_stop`=0 and timeout expiry in the same cycle: counts as completion, with the NACK latch as sampled.
- `xfer_nack` in the same cycle as `xfer_stop`=0: latched, and counts as a NACK.
- `MR_n` low mid-transfer: immediate return to reset values, and PWRUP restarts. `start` must not glitch high.
- `reconfigure` outside DONE/ERROR: ignored.

## Configuration
- `HDMI_TX_HPD_REINIT_EN`: when defined, adds an input `hpd` (1 bit) with a 2-flop synchroniser.
  - A rising edge of synchronised `hpd` in DONE or ERROR acts as `reconfigure`.
  - A rising edge in any other state is held pending and is serviced on entering DONE/ERROR.
- Undefined: no `hpd` port; only `reconfigure` restarts.

## Test plan
- Power-up, POWERUP_DELAY=10, controller model always ACKs:
  - First `start` at cycle 11 after MR_n release.
  - 10 transfers with `register_data` 4110…1630.
  - `config_done`=1, `busy`=0.
- NACK on entry 2, first two attempts:
  - Entry 2 issued 3 times, `entry_index` holds 2.
  - Completes with `config_done`=1, `config_error`=0.
- NACK forever on entry 0, MAX_RETRY=3:
  - Exactly 4 `start` pulses, then `config_error`=1, `entry_index`=0, `busy`=0.
- Controller never drops `xfer_stop`, TIMEOUT=64:
  - CHECK entered 64 cycles after WAIT entry; treated as NACK; retry increments.
- MR_n pulsed low while entry 5 is in WAIT:
  - All outputs return to reset values within the assertion.
  - Sequence restarts at PWRUP and index 0.
- With HDMI_TX_HPD_REINIT_EN, `hpd` rises after DONE:
  - `config_done` clears 3 cycles later (synchroniser plus edge detect).
  - Table rewritten from entry 0 with no power-up delay.

Source files
------------

// File: rtl/hdmi_tx_config_sequencer.sv
// HDMI TX power-up register programming, one 3-byte I2C write per table entry.
// Optional HPD-triggered reprogramming: define HDMI_TX_HPD_REINIT_EN.
`timescale 1ns/1ps
module hdmi_tx_config_sequencer #(
    parameter logic [7:0] SLAVE_ADDR    = 8'h72,
    parameter int         NUM_REGS      = 10,
    parameter int         POWERUP_DELAY = 20000,
    parameter int         GAP_CYCLES    = 4,
    parameter int         MAX_RETRY     = 3,
    parameter int         TIMEOUT       = 64
) (
    input  logic        clock,
    input  logic        MR_n,
    input  logic        reconfigure,
    input  logic        xfer_stop,
    input  logic        xfer_nack,
`ifdef HDMI_TX_HPD_REINIT_EN
    input  logic        hpd,
`endif
    output logic        start,
    output logic [7:0]  slave_address,
    output logic [15:0] register_data,
    output logic        busy,
    output logic        config_done,
    output logic        config_error,
    output logic [7:0]  entry_index
);

    localparam int PW_W = $clog2(POWERUP_DELAY + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int GP_W = $clog2(GAP_CYCLES + 2);
    localparam int RT_W = $clog2(MAX_RETRY + 2);
    localparam bit NO_GAP = (GAP_CYCLES == 0);

    typedef enum logic [2:0] {
        S_PWRUP, S_LOAD, S_START, S_WAIT,
        S_CHECK, S_GAP, S_DONE, S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [PW_W-1:0] pwr_q, pwr_d;
    logic [TO_W-1:0] tmo_q, tmo_d;
    logic [GP_W-1:0] gap_q, gap_d;
    logic [RT_W-1:0] retry_q, retry_d;
    logic [7:0]  idx_q, idx_d;
    logic        nack_q, nack_d;
    logic        start_q, start_d;
    logic [15:0] data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        restart;

    function automatic logic [15:0] rom(input logic [7:0] i);
        logic [15:0] v;
        case (i)
            8'd0:    v = 16'h4110;
            8'd1:    v = 16'h9803;
            8'd2:    v = 16'h9AE0;
            8'd3:    v = 16'h9C30;
            8'd4:    v = 16'h9D61;
            8'd5:    v = 16'hA2A4;
            8'd6:    v = 16'hA3A4;
            8'd7:    v = 16'hE0D0;
            8'd8:    v = 16'hF900;
            8'd9:    v = 16'h1630;
            default: v = 16'h0000;
        endcase
        return (int'(i) < NUM_REGS) ? v : 16'h0000;
    endfunction

`ifdef HDMI_TX_HPD_REINIT_EN
    logic hpd_s1_q, hpd_s2_q, hpd_d3_q;
    logic pend_q, pend_d;
    logic hpd_rise;
    logic in_final;

    assign hpd_rise = hpd_s2_q & ~hpd_d3_q;
    assign in_final = (state_q == S_DONE) || (state_q == S_ERROR);
    assign restart  = reconfigure | hpd_rise | pend_q;

    // An edge seen mid-sequence is remembered until the sequence ends
    always_comb begin
        pend_d = pend_q;
        if (in_final && restart) begin
            pend_d = 1'b0;
        end else if (hpd_rise && !in_final) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge MR_n) begin
        if (!MR_n) begin
            hpd_s1_q <= 1'b0;
            hpd_s2_q <= 1'b0;
            hpd_d3_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            hpd_s1_q <= hpd;
            hpd_s2_q <= hpd_s1_q;
            hpd_d3_q <= hpd_s2_q;
            pend_q   <= pend_d;
        end
    end
`else
    assign restart = reconfigure;
`endif

    always_comb begin
        state_d = state_q;
        pwr_d   = pwr_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        retry_d = retry_q;
        idx_d   = idx_q;
        nack_d  = nack_q;
        data_d  = data_q;

        unique case (state_q)
            S_PWRUP: begin
                if (pwr_q == '0) begin
                    state_d = S_LOAD;
                    idx_d   = 8'd0;
                    retry_d = '0;
                end else begin
                    pwr_d = pwr_q - PW_W'(1);
                end
            end
            S_LOAD: begin
                data_d  = rom(idx_q);
                state_d = S_START;
            end
            S_START: begin
                nack_d  = 1'b0;
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // The controller drops ack before stop, so keep it sticky
                nack_d = nack_q | xfer_nack;
                if (!xfer_stop) begin
                    state_d = S_CHECK;
                end else if (tmo_q == TO_W'(TIMEOUT - 1)) begin
                    nack_d  = 1'b1;
                    state_d = S_CHECK;
                end else begin
                    tmo_d = tmo_q + TO_W'(1);
                end
            end
            S_CHECK: begin
                if (nack_q) begin
                    if (retry_q < RT_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RT_W'(1);
                        gap_d   = GP_W'(NO_GAP ? 0 : GAP_CYCLES - 1);
                        state_d = NO_GAP ? S_LOAD : S_GAP;
                    end else begin
                        state_d = S_ERROR;
                    end
                end else begin
                    retry_d = '0;
                    if (idx_q == 8'(NUM_REGS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        gap_d   = GP_W'(NO_GAP ? 0 : GAP_CYCLES - 1);
                        state_d = NO_GAP ? S_LOAD : S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_LOAD;
                end else begin
                    gap_d = gap_q - GP_W'(1);
                end
            end
            S_DONE, S_ERROR: begin
                if (restart) begin
                    idx_d   = 8'd0;
                    retry_d = '0;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_PWRUP;
        endcase

        // Outputs are registered copies of the next state
        start_d = (state_d == S_START);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERROR);
        busy_d  = !((state_d == S_PWRUP) || (state_d == S_DONE)
                    || (state_d == S_ERROR));
    end

    always_ff @(posedge clock or negedge MR_n) begin
        if (!MR_n) begin
            state_q <= S_PWRUP;
            pwr_q   <= PW_W'(POWERUP_DELAY - 1);
            tmo_q   <= '0;
            gap_q   <= '0;
            retry_q <= '0;
            idx_q   <= 8'd0;
            nack_q  <= 1'b0;
            start_q <= 1'b0;
            data_q  <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pwr_q   <= pwr_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            retry_q <= retry_d;
            idx_q   <= idx_d;
            nack_q  <= nack_d;
            start_q <= start_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign start         = start_q;
    assign slave_address = SLAVE_ADDR;
    assign register_data = data_q;
    assign busy          = busy_q;
    assign config_done   = done_q;
    assign config_error  = err_q;
    assign entry_index   = idx_q;

endmodule

// File: tb/tb_hdmi_tx_config_sequencer.sv
// Bench for hdmi_tx_config_sequencer: I2C controller model plus
// a scoreboard of expected {index, data} per start pulse.
`timescale 1ns/1ps
module tb_hdmi_tx_config_sequencer;

    localparam int PWR  = 10;
    localparam int NREG = 10;
    localparam int GAPC = 4;
    localparam int MAXR = 3;
    localparam int TMO  = 64;
    localparam int LAT  = 8;

    logic        clock = 1'b0;
    logic        MR_n;
    logic        reconfigure;
    logic        xfer_stop;
    logic        xfer_nack;
`ifdef HDMI_TX_HPD_REINIT_EN
    logic        hpd;
`endif
    logic        start;
    logic [7:0]  slave_address;
    logic [15:0] register_data;
    logic        busy;
    logic        config_done;
    logic        config_error;
    logic [7:0]  entry_index;

    always #5 clock = ~clock;

    hdmi_tx_config_sequencer #(
        .SLAVE_ADDR    (8'h72),
        .NUM_REGS      (NREG),
        .POWERUP_DELAY (PWR),
        .GAP_CYCLES    (GAPC),
        .MAX_RETRY     (MAXR),
        .TIMEOUT       (TMO)
    ) u_dut (
        .clock         (clock),
        .MR_n          (MR_n),
        .reconfigure   (reconfigure),
        .xfer_stop     (xfer_stop),
        .xfer_nack     (xfer_nack),
`ifdef HDMI_TX_HPD_REINIT_EN
        .hpd           (hpd),
`endif
        .start         (start),
        .slave_address (slave_address),
        .register_data (register_data),
        .busy          (busy),
        .config_done   (config_done),
        .config_error  (config_error),
        .entry_index   (entry_index)
    );

    typedef struct packed {
        logic [7:0]  idx;
        logic [15:0] data;
    } exp_t;

    logic [15:0] tbl [10] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30,
                              16'h9D61, 16'hA2A4, 16'hA3A4, 16'hE0D0,
                              16'hF900, 16'h1630};

    exp_t sb[$];
    int   st_cyc[$];
    int   errs = 0;
    int   checks = 0;
    int   n_starts = 0;
    int   cyc = 0;
    int   nack_entry = -1;
    int   nack_left = 0;
    bit   hang = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic push_e(input int i);
        exp_t e;
        e.idx  = 8'(i);
        e.data = tbl[i];
        sb.push_back(e);
    endtask

    task automatic chk_reset();
        chk("rst_start", start, 0);
        chk("rst_data", register_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", config_done, 0);
        chk("rst_error", config_error, 0);
        chk("rst_index", entry_index, 0);
        chk("rst_slave", slave_address, 32'h72);
    endtask

    task automatic first_start(input string tag);
        int  c;
        bit  seen;
        c = 0;
        seen = 1'b0;
        while (c < 50 && !seen) begin
            @(posedge clock);
            c++;
            #1;
            seen = start;
        end
        chk(tag, c, PWR + 1);
    endtask

    task automatic wait_end(input int bound);
        int c;
        c = 0;
        while (!(config_done || config_error) && c < bound) begin
            @(negedge clock);
            c++;
        end
    endtask

    task automatic pulse_reconf();
        @(negedge clock);
        reconfigure = 1'b1;
        @(negedge clock);
        reconfigure = 1'b0;
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin : mon
        exp_t e;
        if (MR_n && start === 1'b1) begin
            n_starts++;
            st_cyc.push_back(cyc);
            chk("start_while_stop_low", xfer_stop, 1);
            if (sb.size() == 0) begin
                chk("unexpected_start", entry_index, 32'hFFFF);
            end else begin
                e = sb.pop_front();
                chk("entry_index", entry_index, e.idx);
                chk("register_data", register_data, e.data);
            end
        end
    end

    // I2C controller model: NACK pulse mid-transfer, stop low for one cycle
    initial begin : ctrl
        bit nack_now;
        xfer_stop = 1'b1;
        xfer_nack = 1'b0;
        forever begin
            @(negedge clock);
            if (MR_n && start && !hang) begin
                nack_now = (int'(entry_index) == nack_entry) && (nack_left > 0);
                if (nack_now) nack_left--;
                repeat (3) @(negedge clock);
                xfer_nack = nack_now;
                @(negedge clock);
                xfer_nack = 1'b0;
                repeat (LAT) @(negedge clock);
                xfer_stop = 1'b0;
                @(negedge clock);
                xfer_stop = 1'b1;
            end
        end
    end

    initial begin : main
        int s0;
        int sp;
        int c;
        MR_n = 1'b0;
        reconfigure = 1'b0;
`ifdef HDMI_TX_HPD_REINIT_EN
        hpd = 1'b0;
`endif
        repeat (3) @(negedge clock);
        chk_reset();

        // power-up, all ACK
        for (int i = 0; i < NREG; i++) push_e(i);
        MR_n = 1'b1;
        first_start("pwrup_latency");
        wait_end(3000);
        chk("pwrup_done", config_done, 1);
        chk("pwrup_busy", busy, 0);
        chk("pwrup_err", config_error, 0);
        chk("pwrup_starts", n_starts, NREG);
        chk("pwrup_sb_empty", sb.size(), 0);

        // NACK twice on entry 2; a stray reconfigure mid-run is ignored
        s0 = n_starts;
        nack_entry = 2;
        nack_left = 2;
        for (int i = 0; i < 3; i++) push_e(i);
        for (int i = 0; i < 2; i++) push_e(2);
        for (int i = 3; i < NREG; i++) push_e(i);
        pulse_reconf();
        chk("reconf_clears_done", config_done, 0);
        chk("reconf_busy", busy, 1);
        repeat (40) @(negedge clock);
        pulse_reconf();
        wait_end(3000);
        chk("retry_done", config_done, 1);
        chk("retry_err", config_error, 0);
        chk("retry_starts", n_starts - s0, NREG + 2);
        chk("retry_sb_empty", sb.size(), 0);

        // NACK forever on entry 0
        s0 = n_starts;
        nack_entry = 0;
        nack_left = 1000;
        for (int i = 0; i < MAXR + 1; i++) push_e(0);
        pulse_reconf();
        wait_end(3000);
        repeat (20) @(negedge clock);
        chk("nack_err", config_error, 1);
        chk("nack_done", config_done, 0);
        chk("nack_index", entry_index, 0);
        chk("nack_busy", busy, 0);
        chk("nack_starts", n_starts - s0, MAXR + 1);
        nack_left = 0;
        nack_entry = -1;

        // controller hangs: every attempt times out
        s0 = n_starts;
        hang = 1'b1;
        for (int i = 0; i < MAXR + 1; i++) push_e(0);
        pulse_reconf();
        wait_end(3000);
        chk("tmo_err", config_error, 1);
        chk("tmo_starts", n_starts - s0, MAXR + 1);
        sp = (st_cyc.size() > s0 + 1) ? st_cyc[s0 + 1] - st_cyc[s0] : -1;
        chk("tmo_spacing", sp, 1 + TMO + 1 + GAPC + 1);
        hang = 1'b0;

        // reset while entry 5 is in flight
        s0 = n_starts;
        for (int i = 0; i < 6; i++) push_e(i);
        pulse_reconf();
        c = 0;
        while (c < 3000 && !(start && entry_index == 8'd5)) begin
            @(negedge clock);
            c++;
        end
        chk("mr_reached_entry5", entry_index, 5);
        repeat (4) @(negedge clock);
        MR_n = 1'b0;
        #1;
        chk_reset();
        repeat (3) @(negedge clock);
        chk("mr_start_low", start, 0);
        chk("mr_sb_empty", sb.size(), 0);
        s0 = n_starts;
        for (int i = 0; i < NREG; i++) push_e(i);
        MR_n = 1'b1;
        first_start("mr_pwrup_latency");
        wait_end(3000);
        chk("mr_done", config_done, 1);
        chk("mr_starts", n_starts - s0, NREG);

`ifdef HDMI_TX_HPD_REINIT_EN
        // hot-plug after DONE rewrites the table
        s0 = n_starts;
        for (int i = 0; i < NREG; i++) push_e(i);
        @(negedge clock);
        hpd = 1'b1;
        @(posedge clock);
        #1;
        chk("hpd_done_c1", config_done, 1);
        @(posedge clock);
        #1;
        chk("hpd_done_c2", config_done, 1);
        @(posedge clock);
        #1;
        chk("hpd_done_c3", config_done, 0);
        @(posedge clock);
        #1;
        chk("hpd_start_fast", start, 1);
        wait_end(3000);
        chk("hpd_done", config_done, 1);
        chk("hpd_starts", n_starts - s0, NREG);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
